axi_lite_master_bridge: RTL and testbench
=========================================

// Module: axi_lite_master_bridge
// PURPOSE
//  AXI4-Lite initiator: turns the core's single-request load/store port into AXI read (AR/R) or write (AW/W/B) transactions.
//  One instance sits on the fetch path (ALLOW_WRITE=0) and one on the LSU path (ALLOW_WRITE=1), each driving one slave port of the memory wrapper.
//  Exactly one outstanding transaction per instance; no bursts, no IDs.
// PARAMETERS
//  ADDR_BITS    AXI_ADDR_BITS  address width (req_addr, ARADDR, AWADDR)
//  DATA_BITS    AXI_DATA_BITS  data width; strobe width = DATA_BITS/8
//  ALLOW_WRITE  1              0: write requests are rejected locally, no AXI activity
// PORTS
//  ACLK        in   1            clock; all logic on rising edge
//  ARESET      in   1            synchronous, active-high reset
//  req_valid   in   1            core request valid
//  req_ready   out  1            bridge can accept (high only in IDLE)
//  req_we      in   1            1=write, 0=read
//  req_addr    in   ADDR_BITS    byte address, passed unmodified to AxADDR
//  req_wdata   in   DATA_BITS    write data
//  req_wstrb   in   DATA_BITS/8  write byte strobes
//  resp_valid  out  1            response valid, held until resp_ready
//  resp_ready  in   1            core accepts response
//  resp_rdata  out  DATA_BITS    read data (0 for writes)
//  resp_err    out  1            xRESP != AXI_RESP_OKAY, or write rejected
//  ARADDR/ARVALID out, ARREADY in; RDATA/RRESP/RVALID in, RREADY out
//  AWADDR/AWVALID out, AWREADY in; WDATA/WSTRB/WVALID out, WREADY in
//  BRESP/BVALID in, BREADY out   (widths per defs: ADDR_BITS, DATA_BITS, 2-bit resp)
// BEHAVIOUR
//  - Reset: state=IDLE; ARVALID/AWVALID/WVALID/RREADY/BREADY/resp_valid=0; ARADDR/AWADDR/WDATA/resp_rdata=0; WSTRB=0; resp_err=0. req_ready=1 the cycle after reset deasserts.
//  - All AXI outputs and resp_* are registered; req_ready = (state==IDLE), combinational.
//  - FSM: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
//  - IDLE, req_valid&&!req_we: latch addr, ARVALID<=1 -> RD_ADDR.
//  - RD_ADDR: hold ARVALID/ARADDR stable until ARREADY; then ARVALID<=0, RREADY<=1 -> RD_DATA.
//  - RD_DATA: on RVALID: resp_rdata<=RDATA, resp_err<=(RRESP!=OKAY), RREADY<=0, resp_valid<=1 -> RESP.
//  - IDLE, req_valid&&req_we&&ALLOW_WRITE: AWVALID<=1, WVALID<=1 same edge -> WR_REQ.
//  - WR_REQ: AW and W done flags tracked independently; each VALID drops on its own handshake. Both in same cycle, or the second after the first -> BREADY<=1 -> WR_RESP.
//  - WR_RESP: on BVALID: resp_err<=(BRESP!=OKAY), resp_rdata<=0, BREADY<=0, resp_valid<=1 -> RESP.
//  - IDLE, req_valid&&req_we&&!ALLOW_WRITE: resp_valid<=1, resp_err<=1 -> RESP; no AXI valid asserted.
//  - RESP: hold resp_* until resp_ready; then resp_valid<=0 -> IDLE. Next request accepted one cycle after resp handshake.
//  - Latency vs. always-ready slave with 2-cycle read: req accepted t0, ARVALID t1, RVALID t3, resp_valid t4.
//  - AXI VALID never withdrawn before handshake; address/data stable while VALID high.
//  - RVALID/BVALID outside RD_DATA/WR_RESP are ignored (READY low).
//  - ARESET mid-transaction: all state and outputs return to reset values on that edge; in-flight slave response is dropped.
// STRUCTURE
//  - defs package: AXI_ADDR_BITS, AXI_DATA_BITS, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR; add axi_master_state_e enum there for bench visibility.
//  - Single flat module; no sub-module warranted.
// TESTING
//  1. Read 0x0000_0010, slave ARREADY=1, RDATA=0xDEAD_BEEF after 2 cycles -> one AR handshake, resp_rdata=0xDEAD_BEEF, resp_err=0, resp_valid at t4.
//  2. Write 0x0000_0020 data 0x1234_5678 wstrb 4'b0011; AWREADY t2, WREADY t4 -> AWVALID drops t3, WVALID drops t5, BREADY from t5, resp_err=0.
//  3. Read with ARREADY low 5 cycles -> ARVALID/ARADDR stable all 5 cycles, req_ready=0, single response.
//  4. BRESP=SLVERR (2'b10) -> resp_err=1, resp_rdata=0; RRESP=DECERR on read -> resp_err=1.
//  5. ALLOW_WRITE=0, write request -> resp_valid+resp_err next cycle, AWVALID/WVALID never high.
//  6. resp_ready low 3 cycles with back-to-back req_valid -> resp held, req_ready=0; ARESET during RD_DATA -> all outputs zero next cycle, req_ready=1.

Source files
------------

// File: rtl/axi_lite_master_bridge_pkg.sv
// Shared AXI4-Lite definitions for the master bridge: bus widths, response
// codes and the bridge FSM state encoding (also used by the testbench).
package axi_lite_master_bridge_pkg;

    localparam int AXI_ADDR_BITS = 32;
    localparam int AXI_DATA_BITS = 32;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_RESP    = 3'd5
    } axi_master_state_e;

endpackage

// File: rtl/axi_lite_master_bridge.sv
// AXI4-Lite initiator for a single-request core port. One transaction in
// flight at a time. Every AXI output and every resp_* output is a register;
// only req_ready is decoded combinationally from the state.
//
// Handshake rule on every channel: a transfer happens on a rising edge where
// VALID and READY are both high; a VALID, once raised, stays high with its
// payload unchanged until that edge, and this bridge only raises a READY in
// the state that consumes the matching response.
module axi_lite_master_bridge
    import axi_lite_master_bridge_pkg::*;
#(
    parameter int ADDR_BITS   = AXI_ADDR_BITS,
    parameter int DATA_BITS   = AXI_DATA_BITS,
    parameter int ALLOW_WRITE = 1
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_BITS-1:0]   req_addr,
    input  logic [DATA_BITS-1:0]   req_wdata,
    input  logic [DATA_BITS/8-1:0] req_wstrb,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [DATA_BITS-1:0]   resp_rdata,
    output logic                   resp_err,
    output logic [ADDR_BITS-1:0]   ARADDR,
    output logic                   ARVALID,
    input  logic                   ARREADY,
    input  logic [DATA_BITS-1:0]   RDATA,
    input  logic [1:0]             RRESP,
    input  logic                   RVALID,
    output logic                   RREADY,
    output logic [ADDR_BITS-1:0]   AWADDR,
    output logic                   AWVALID,
    input  logic                   AWREADY,
    output logic [DATA_BITS-1:0]   WDATA,
    output logic [DATA_BITS/8-1:0] WSTRB,
    output logic                   WVALID,
    input  logic                   WREADY,
    input  logic [1:0]             BRESP,
    input  logic                   BVALID,
    output logic                   BREADY,
    output logic [2:0]             fsm_state
);

    axi_master_state_e state, state_n;

    logic                   arvalid_n, rready_n, awvalid_n, wvalid_n, bready_n;
    logic [ADDR_BITS-1:0]   araddr_n, awaddr_n;
    logic [DATA_BITS-1:0]   wdata_n, resp_rdata_n;
    logic [DATA_BITS/8-1:0] wstrb_n;
    logic                   resp_valid_n, resp_err_n;
    logic                   aw_done, w_done, aw_done_n, w_done_n;
    logic                   aw_hs, w_hs;

    assign aw_hs     = AWVALID && AWREADY;
    assign w_hs      = WVALID && WREADY;
    assign req_ready = (state == ST_IDLE);
    assign fsm_state = state;

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        state_n      = state;
        arvalid_n    = ARVALID;
        araddr_n     = ARADDR;
        rready_n     = RREADY;
        awvalid_n    = AWVALID;
        awaddr_n     = AWADDR;
        wvalid_n     = WVALID;
        wdata_n      = WDATA;
        wstrb_n      = WSTRB;
        bready_n     = BREADY;
        resp_valid_n = resp_valid;
        resp_rdata_n = resp_rdata;
        resp_err_n   = resp_err;
        aw_done_n    = aw_done;
        w_done_n     = w_done;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (!req_we) begin
                        araddr_n  = req_addr;
                        arvalid_n = 1'b1;
                        state_n   = ST_RD_ADDR;
                    end else if (ALLOW_WRITE != 0) begin
                        awaddr_n  = req_addr;
                        wdata_n   = req_wdata;
                        wstrb_n   = req_wstrb;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                        aw_done_n = 1'b0;
                        w_done_n  = 1'b0;
                        state_n   = ST_WR_REQ;
                    end else begin
                        // Write on a read-only port: answer locally with an error.
                        resp_valid_n = 1'b1;
                        resp_err_n   = 1'b1;
                        resp_rdata_n = '0;
                        state_n      = ST_RESP;
                    end
                end
            end
            ST_RD_ADDR: begin
                if (ARREADY) begin
                    arvalid_n = 1'b0;
                    rready_n  = 1'b1;
                    state_n   = ST_RD_DATA;
                end
            end
            ST_RD_DATA: begin
                if (RVALID) begin
                    resp_rdata_n = RDATA;
                    resp_err_n   = (RRESP != AXI_RESP_OKAY);
                    rready_n     = 1'b0;
                    resp_valid_n = 1'b1;
                    state_n      = ST_RESP;
                end
            end
            ST_WR_REQ: begin
                // AW and W may complete in either order or together.
                if (aw_hs) begin
                    awvalid_n = 1'b0;
                    aw_done_n = 1'b1;
                end
                if (w_hs) begin
                    wvalid_n = 1'b0;
                    w_done_n = 1'b1;
                end
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    bready_n  = 1'b1;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                    state_n   = ST_WR_RESP;
                end
            end
            ST_WR_RESP: begin
                if (BVALID) begin
                    resp_err_n   = (BRESP != AXI_RESP_OKAY);
                    resp_rdata_n = '0;
                    bready_n     = 1'b0;
                    resp_valid_n = 1'b1;
                    state_n      = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    resp_valid_n = 1'b0;
                    state_n      = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any in-flight transfer.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state      <= ST_IDLE;
            ARVALID    <= 1'b0;
            ARADDR     <= '0;
            RREADY     <= 1'b0;
            AWVALID    <= 1'b0;
            AWADDR     <= '0;
            WVALID     <= 1'b0;
            WDATA      <= '0;
            WSTRB      <= '0;
            BREADY     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state      <= state_n;
            ARVALID    <= arvalid_n;
            ARADDR     <= araddr_n;
            RREADY     <= rready_n;
            AWVALID    <= awvalid_n;
            AWADDR     <= awaddr_n;
            WVALID     <= wvalid_n;
            WDATA      <= wdata_n;
            WSTRB      <= wstrb_n;
            BREADY     <= bready_n;
            resp_valid <= resp_valid_n;
            resp_rdata <= resp_rdata_n;
            resp_err   <= resp_err_n;
            aw_done    <= aw_done_n;
            w_done     <= w_done_n;
        end
    end

endmodule

// File: tb/tb_axi_lite_master_bridge.sv
// Self-checking bench for axi_lite_master_bridge: a write-capable instance
// driven by a scripted slave, plus a read-only instance for write rejection.
module tb_axi_lite_master_bridge;
    import axi_lite_master_bridge_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic ARESET = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals (write-capable) ----------------
    logic        req_valid = 0, req_we = 0, resp_ready = 1;
    logic [31:0] req_addr = 0, req_wdata = 0;
    logic [3:0]  req_wstrb = 0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] ARADDR, AWADDR, WDATA;
    logic        ARVALID, RREADY, AWVALID, WVALID, BREADY;
    logic [3:0]  WSTRB;
    logic        ARREADY = 0, RVALID = 0, AWREADY = 0, WREADY = 0, BVALID = 0;
    logic [31:0] RDATA = 0;
    logic [1:0]  RRESP = 0, BRESP = 0;
    logic [2:0]  fsm_state;

    // ---------------- read-only instance signals ----------------
    logic        req_valid_ro = 0, resp_ready_ro = 1;
    logic        req_ready_ro, resp_valid_ro, resp_err_ro;
    logic [31:0] resp_rdata_ro, ARADDR_ro, AWADDR_ro, WDATA_ro;
    logic        ARVALID_ro, RREADY_ro, AWVALID_ro, WVALID_ro, BREADY_ro;
    logic [3:0]  WSTRB_ro;
    logic [2:0]  fsm_state_ro;
    logic        z1 = 1'b0;
    logic [1:0]  z2 = 2'b00;
    logic [31:0] z32 = 32'h0;

    axi_lite_master_bridge #(.ADDR_BITS(32), .DATA_BITS(32), .ALLOW_WRITE(1)) u_dut (
        .ACLK(clk), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .fsm_state(fsm_state)
    );

    axi_lite_master_bridge #(.ADDR_BITS(32), .DATA_BITS(32), .ALLOW_WRITE(0)) u_ro (
        .ACLK(clk), .ARESET(ARESET),
        .req_valid(req_valid_ro), .req_ready(req_ready_ro), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid_ro), .resp_ready(resp_ready_ro),
        .resp_rdata(resp_rdata_ro), .resp_err(resp_err_ro),
        .ARADDR(ARADDR_ro), .ARVALID(ARVALID_ro), .ARREADY(z1),
        .RDATA(z32), .RRESP(z2), .RVALID(z1), .RREADY(RREADY_ro),
        .AWADDR(AWADDR_ro), .AWVALID(AWVALID_ro), .AWREADY(z1),
        .WDATA(WDATA_ro), .WSTRB(WSTRB_ro), .WVALID(WVALID_ro), .WREADY(z1),
        .BRESP(z2), .BVALID(z1), .BREADY(BREADY_ro),
        .fsm_state(fsm_state_ro)
    );

    // ---------------- bookkeeping ----------------
    int chk_cnt = 0;
    int pass_cnt = 0;
    int ar_hs_cnt = 0;
    bit ro_wr_seen = 0;
    logic [32:0] exp_q[$];   // {resp_err, resp_rdata}

    // Count AR handshakes and catch any AXI write activity on the read-only port.
    initial forever begin
        @(posedge clk);
        if (!ARESET && ARVALID && ARREADY) ar_hs_cnt++;
        if (AWVALID_ro || WVALID_ro) ro_wr_seen = 1;
    end

    // Scoreboard: compare every response handshake against the expected queue.
    initial forever begin
        logic [32:0] exp;
        @(negedge clk);
        if (!ARESET && resp_valid && resp_ready) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected_resp got err=%0b rdata=%08h exp=no response", resp_err, resp_rdata);
            end else begin
                exp = exp_q.pop_front();
                if ({resp_err, resp_rdata} !== exp)
                    $display("FAIL sb_resp got err=%0b rdata=%08h exp err=%0b rdata=%08h",
                             resp_err, resp_rdata, exp[32], exp[31:0]);
                else pass_cnt++;
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        ARESET = 1'b1;
        repeat (3) tick();
        chk_cnt++; if ({ARVALID, AWVALID, WVALID, RREADY, BREADY, resp_valid, resp_err} !== 7'b0) $display("FAIL reset_ctrl got=%07b exp=0000000", {ARVALID, AWVALID, WVALID, RREADY, BREADY, resp_valid, resp_err}); else pass_cnt++;
        chk_cnt++; if ({ARADDR, AWADDR, WDATA, resp_rdata, WSTRB} !== 132'h0) $display("FAIL reset_data got araddr=%08h awaddr=%08h wdata=%08h rdata=%08h wstrb=%0h exp=0", ARADDR, AWADDR, WDATA, resp_rdata, WSTRB); else pass_cnt++;
        ARESET = 1'b0;
        tick();
        chk_cnt++; if (req_ready !== 1'b1 || fsm_state !== ST_IDLE) $display("FAIL reset_idle got req_ready=%0b state=%0d exp=1/0", req_ready, fsm_state); else pass_cnt++;
    endtask

    task automatic test_read_basic();
        int hs0;
        hs0 = ar_hs_cnt;
        req_valid = 1; req_we = 0; req_addr = 32'h0000_0010;
        exp_q.push_back({1'b0, 32'hDEAD_BEEF});
        tick();                                        // t1
        req_valid = 0; ARREADY = 1;
        chk_cnt++; if (ARVALID !== 1'b1 || ARADDR !== 32'h10) $display("FAIL rd_t1_ar got valid=%0b addr=%08h exp=1/00000010", ARVALID, ARADDR); else pass_cnt++;
        chk_cnt++; if (req_ready !== 1'b0) $display("FAIL rd_t1_req_ready got=%0b exp=0", req_ready); else pass_cnt++;
        tick();                                        // t2
        ARREADY = 0;
        chk_cnt++; if (ARVALID !== 1'b0 || RREADY !== 1'b1) $display("FAIL rd_t2 got arvalid=%0b rready=%0b exp=0/1", ARVALID, RREADY); else pass_cnt++;
        tick();                                        // t3
        RVALID = 1; RDATA = 32'hDEAD_BEEF; RRESP = AXI_RESP_OKAY;
        chk_cnt++; if (resp_valid !== 1'b0) $display("FAIL rd_t3_resp_valid got=%0b exp=0", resp_valid); else pass_cnt++;
        tick();                                        // t4
        RVALID = 0;
        chk_cnt++; if (resp_valid !== 1'b1 || RREADY !== 1'b0) $display("FAIL rd_t4 got resp_valid=%0b rready=%0b exp=1/0", resp_valid, RREADY); else pass_cnt++;
        tick();                                        // t5
        chk_cnt++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL rd_t5 got resp_valid=%0b req_ready=%0b exp=0/1", resp_valid, req_ready); else pass_cnt++;
        chk_cnt++; if (ar_hs_cnt - hs0 !== 1) $display("FAIL rd_ar_hs_count got=%0d exp=1", ar_hs_cnt - hs0); else pass_cnt++;
    endtask

    task automatic test_write_split();
        req_valid = 1; req_we = 1; req_addr = 32'h0000_0020;
        req_wdata = 32'h1234_5678; req_wstrb = 4'b0011;
        exp_q.push_back({1'b0, 32'h0});
        tick();                                        // t1
        req_valid = 0;
        chk_cnt++; if (AWVALID !== 1'b1 || WVALID !== 1'b1) $display("FAIL wr_t1_valid got aw=%0b w=%0b exp=1/1", AWVALID, WVALID); else pass_cnt++;
        chk_cnt++; if (AWADDR !== 32'h20 || WDATA !== 32'h1234_5678 || WSTRB !== 4'b0011) $display("FAIL wr_t1_payload got addr=%08h data=%08h strb=%0h exp=00000020/12345678/3", AWADDR, WDATA, WSTRB); else pass_cnt++;
        tick();                                        // t2
        AWREADY = 1;
        tick();                                        // t3
        AWREADY = 0;
        chk_cnt++; if (AWVALID !== 1'b0 || WVALID !== 1'b1 || BREADY !== 1'b0) $display("FAIL wr_t3 got aw=%0b w=%0b bready=%0b exp=0/1/0", AWVALID, WVALID, BREADY); else pass_cnt++;
        tick();                                        // t4
        WREADY = 1;
        chk_cnt++; if (WVALID !== 1'b1 || WDATA !== 32'h1234_5678) $display("FAIL wr_t4_w_hold got w=%0b data=%08h exp=1/12345678", WVALID, WDATA); else pass_cnt++;
        tick();                                        // t5
        WREADY = 0;
        chk_cnt++; if (WVALID !== 1'b0 || BREADY !== 1'b1) $display("FAIL wr_t5 got w=%0b bready=%0b exp=0/1", WVALID, BREADY); else pass_cnt++;
        BVALID = 1; BRESP = AXI_RESP_OKAY;
        tick();                                        // t6
        BVALID = 0;
        chk_cnt++; if (resp_valid !== 1'b1 || BREADY !== 1'b0) $display("FAIL wr_t6 got resp_valid=%0b bready=%0b exp=1/0", resp_valid, BREADY); else pass_cnt++;
        tick();
    endtask

    task automatic test_read_stall();
        logic [31:0] a, d;
        int hs0;
        a = $urandom; d = $urandom;
        hs0 = ar_hs_cnt;
        req_valid = 1; req_we = 0; req_addr = a;
        exp_q.push_back({1'b0, d});
        tick();
        req_valid = 0; req_addr = ~a;
        for (int i = 0; i < 5; i++) begin
            chk_cnt++; if (ARVALID !== 1'b1 || ARADDR !== a || req_ready !== 1'b0) $display("FAIL stall_c%0d got arvalid=%0b araddr=%08h req_ready=%0b exp=1/%08h/0", i, ARVALID, ARADDR, req_ready, a); else pass_cnt++;
            tick();
        end
        ARREADY = 1;
        tick();
        ARREADY = 0; RVALID = 1; RDATA = d; RRESP = AXI_RESP_OKAY;
        tick();
        RVALID = 0;
        chk_cnt++; if (resp_valid !== 1'b1) $display("FAIL stall_resp_valid got=%0b exp=1", resp_valid); else pass_cnt++;
        tick();
        chk_cnt++; if (ar_hs_cnt - hs0 !== 1) $display("FAIL stall_ar_hs_count got=%0d exp=1", ar_hs_cnt - hs0); else pass_cnt++;
    endtask

    task automatic test_error_resp();
        req_valid = 1; req_we = 1; req_addr = 32'h44; req_wdata = 32'hA5A5_A5A5; req_wstrb = 4'hF;
        AWREADY = 1; WREADY = 1;
        exp_q.push_back({1'b1, 32'h0});
        tick();
        req_valid = 0;
        tick();
        AWREADY = 0; WREADY = 0;
        chk_cnt++; if (AWVALID !== 1'b0 || WVALID !== 1'b0 || BREADY !== 1'b1) $display("FAIL err_wr_both got aw=%0b w=%0b bready=%0b exp=0/0/1", AWVALID, WVALID, BREADY); else pass_cnt++;
        BVALID = 1; BRESP = AXI_RESP_SLVERR;
        tick();
        BVALID = 0; BRESP = AXI_RESP_OKAY;
        chk_cnt++; if (resp_err !== 1'b1 || resp_rdata !== 32'h0) $display("FAIL err_slverr got err=%0b rdata=%08h exp=1/00000000", resp_err, resp_rdata); else pass_cnt++;
        tick();
        req_valid = 1; req_we = 0; req_addr = 32'h88; ARREADY = 1;
        exp_q.push_back({1'b1, 32'hCAFE_0001});
        tick();
        req_valid = 0;
        tick();
        ARREADY = 0; RVALID = 1; RDATA = 32'hCAFE_0001; RRESP = AXI_RESP_DECERR;
        tick();
        RVALID = 0; RRESP = AXI_RESP_OKAY;
        chk_cnt++; if (resp_err !== 1'b1) $display("FAIL err_decerr got=%0b exp=1", resp_err); else pass_cnt++;
        tick();
    endtask

    task automatic test_write_rejected();
        req_valid_ro = 1; req_we = 1; req_addr = 32'h100; req_wdata = 32'h55; req_wstrb = 4'hF;
        tick();
        req_valid_ro = 0;
        chk_cnt++; if (resp_valid_ro !== 1'b1 || resp_err_ro !== 1'b1 || resp_rdata_ro !== 32'h0) $display("FAIL ro_resp got valid=%0b err=%0b rdata=%08h exp=1/1/0", resp_valid_ro, resp_err_ro, resp_rdata_ro); else pass_cnt++;
        chk_cnt++; if (AWVALID_ro !== 1'b0 || WVALID_ro !== 1'b0) $display("FAIL ro_no_axi got aw=%0b w=%0b exp=0/0", AWVALID_ro, WVALID_ro); else pass_cnt++;
        tick();
        chk_cnt++; if (resp_valid_ro !== 1'b0 || req_ready_ro !== 1'b1) $display("FAIL ro_done got valid=%0b req_ready=%0b exp=0/1", resp_valid_ro, req_ready_ro); else pass_cnt++;
    endtask

    task automatic test_random_reads();
        for (int n = 0; n < 6; n++) begin
            logic [31:0] a, d;
            int ar_wait, r_wait;
            a = $urandom; d = $urandom;
            ar_wait = $urandom_range(0, 3); r_wait = $urandom_range(0, 3);
            req_valid = 1; req_we = 0; req_addr = a;
            exp_q.push_back({1'b0, d});
            tick();
            req_valid = 0;
            repeat (ar_wait) tick();
            chk_cnt++; if (ARVALID !== 1'b1 || ARADDR !== a) $display("FAIL rnd%0d_ar got valid=%0b addr=%08h exp=1/%08h", n, ARVALID, ARADDR, a); else pass_cnt++;
            ARREADY = 1;
            tick();
            ARREADY = 0;
            repeat (r_wait) tick();
            RVALID = 1; RDATA = d; RRESP = AXI_RESP_OKAY;
            tick();
            RVALID = 0;
            chk_cnt++; if (resp_valid !== 1'b1) $display("FAIL rnd%0d_resp_valid got=%0b exp=1", n, resp_valid); else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_back_to_back_and_reset();
        resp_ready = 0;
        req_valid = 1; req_we = 0; req_addr = 32'h0000_0300; ARREADY = 1;
        exp_q.push_back({1'b0, 32'h1111_2222});
        tick();                                        // t1
        tick();                                        // t2
        RVALID = 1; RDATA = 32'h1111_2222; RRESP = AXI_RESP_OKAY;
        tick();                                        // t3
        RVALID = 0;
        for (int i = 0; i < 3; i++) begin
            chk_cnt++; if (resp_valid !== 1'b1 || resp_rdata !== 32'h1111_2222 || req_ready !== 1'b0) $display("FAIL b2b_hold%0d got valid=%0b rdata=%08h req_ready=%0b exp=1/11112222/0", i, resp_valid, resp_rdata, req_ready); else pass_cnt++;
            tick();
        end
        resp_ready = 1; req_addr = 32'h0000_0400;
        exp_q.push_back({1'b0, 32'h3333_4444});
        tick();                                        // resp handshake done
        chk_cnt++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL b2b_idle got valid=%0b req_ready=%0b exp=0/1", resp_valid, req_ready); else pass_cnt++;
        tick();                                        // second request accepted
        req_valid = 0;
        chk_cnt++; if (ARVALID !== 1'b1 || ARADDR !== 32'h400) $display("FAIL b2b_second_ar got valid=%0b addr=%08h exp=1/00000400", ARVALID, ARADDR); else pass_cnt++;
        tick();                                        // RD_DATA
        chk_cnt++; if (RREADY !== 1'b1 || fsm_state !== ST_RD_DATA) $display("FAIL b2b_rd_data got rready=%0b state=%0d exp=1/2", RREADY, fsm_state); else pass_cnt++;
        ARESET = 1; RVALID = 1; RDATA = 32'h3333_4444;
        void'(exp_q.pop_back());                       // dropped by reset
        tick();
        ARESET = 0; RVALID = 0; ARREADY = 0;
        chk_cnt++; if ({ARVALID, AWVALID, WVALID, RREADY, BREADY, resp_valid, resp_err} !== 7'b0) $display("FAIL arst_ctrl got=%07b exp=0000000", {ARVALID, AWVALID, WVALID, RREADY, BREADY, resp_valid, resp_err}); else pass_cnt++;
        chk_cnt++; if ({ARADDR, resp_rdata} !== 64'h0 || req_ready !== 1'b1) $display("FAIL arst_data got araddr=%08h rdata=%08h req_ready=%0b exp=0/0/1", ARADDR, resp_rdata, req_ready); else pass_cnt++;
        repeat (3) tick();
        chk_cnt++; if (resp_valid !== 1'b0) $display("FAIL arst_no_resp got=%0b exp=0", resp_valid); else pass_cnt++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_read_basic();
        test_write_split();
        test_read_stall();
        test_error_resp();
        test_write_rejected();
        test_random_reads();
        test_back_to_back_and_reset();
        repeat (2) tick();
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", exp_q.size()); else pass_cnt++;
        chk_cnt++; if (ro_wr_seen !== 1'b0) $display("FAIL ro_axi_write_seen got=%0b exp=0", ro_wr_seen); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    // Watchdog against a stalled run.
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
